// File: rtl/pim_result_collector_pkg.sv
// Shared constants, collector state encoding and tile address helpers
// for the PIM result return path.
package pim_result_collector_pkg;

    localparam int NUM_OF_PIM_UNITS = 4;
    localparam int WIDTH            = 32;
    localparam int LEN              = 10;
    localparam int MEM_ELEMENTS     = 1 << LEN;
    localparam int MAT_DIM          = 32;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} col_state_e;

    // Elaboration-time integer square root (grid side from unit count).
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        for (int i = 1; i <= n; i++)
            if (i * i <= n) r = i;
        return r;
    endfunction

    localparam int GRID      = isqrt(NUM_OF_PIM_UNITS);
    localparam int TILE_SIZE = MAT_DIM / GRID;

    // Row-major offset of element k of unit's tile inside the full matrix.
    function automatic int tile_offset(input int unit, input int k, input int grid,
                                       input int tile, input int mat_n);
        return ((unit / grid) * tile + k / tile) * mat_n + (unit % grid) * tile + k % tile;
    endfunction

endpackage

// File: rtl/pim_result_collector_if.sv
// PIM result stream plus result-memory write port. master = collector side.
interface pim_result_collector_if #(
    parameter int NUM_UNITS = 4,
    parameter int DW        = 32,
    parameter int AW        = 10
);
    logic [NUM_UNITS-1:0]         pim_valid;
    logic [NUM_UNITS-1:0][DW-1:0] pim_data;
    logic [NUM_UNITS-1:0]         pim_ready;
    logic                         mem_we;
    logic [AW-1:0]                mem_addr;
    logic [DW-1:0]                mem_wdata;
    logic                         mem_ready;

    modport master (
        input  pim_valid, pim_data, mem_ready,
        output pim_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output pim_valid, pim_data, mem_ready,
        input  pim_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pim_result_collector_arbiter.sv
// Round-robin arbiter: search starts one past the last advanced grant.
module pim_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    int            idx;

    // Walk from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        idx   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)      ptr <= '0;
        else if (adv) ptr <= PW'((int'(gidx) + 1) % N);
    end

endmodule

// File: rtl/pim_result_collector.sv
// Collects per-unit result tiles and writes them row-major into result memory
// through a single-entry output register.
module pim_result_collector
    import pim_result_collector_pkg::*;
#(
    parameter int NUM_UNITS = NUM_OF_PIM_UNITS,
    parameter int MAT_N     = MAT_DIM,
    parameter int DW        = WIDTH,
    parameter int AW        = LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    output logic                  busy,
    output logic                  done,
    pim_result_collector_if.master bus
);
    localparam int G  = isqrt(NUM_UNITS);
    localparam int T  = MAT_N / G;
    localparam int TT = T * T;
    localparam int KW = $clog2(TT + 1);
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    col_state_e                    state, state_nxt;
    logic [AW-1:0]                 base_q;
    logic [NUM_UNITS-1:0][KW-1:0]  k;
    logic [NUM_UNITS-1:0]          fin, req, grant, acc;
    logic                          start_acc, adv, out_empty, all_fin_nxt;
    logic [UW-1:0]                 sel;
    logic [AW-1:0]                 sel_addr;

    assign start_acc     = (state == IDLE) && start;
    assign out_empty     = !bus.mem_we;
    assign req           = bus.pim_valid & ~fin;
    assign bus.pim_ready = ((state == COLLECT) && (out_empty || bus.mem_ready)) ? grant : '0;
    assign acc           = bus.pim_ready & bus.pim_valid;
    assign adv           = |acc;

    pim_rr_arbiter #(.N(NUM_UNITS)) u_arb (
        .clk   (clk),
        .rst   (rst || start_acc),
        .req   (req),
        .adv   (adv),
        .grant (grant)
    );

    // all_fin_nxt counts this cycle's handshake so DRAIN starts right after the last accept.
    always_comb begin
        fin         = '0;
        all_fin_nxt = 1'b1;
        sel         = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            fin[u] = (k[u] == KW'(TT));
            if (!(fin[u] || (acc[u] && k[u] == KW'(TT - 1)))) all_fin_nxt = 1'b0;
            if (grant[u]) sel = UW'(u);
        end
    end

    assign sel_addr = base_q + AW'(tile_offset(int'(sel), int'(k[sel]), G, T, MAT_N));

    always_ff @(posedge clk) begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (rst || start_acc) k[u] <= '0;
            else if (acc[u])      k[u] <= k[u] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else if (adv) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= bus.pim_data[sel];
        end else if (bus.mem_ready) begin
            bus.mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) base_q <= base_addr;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (all_fin_nxt) state_nxt = DRAIN;
            DRAIN:   if (out_empty || bus.mem_ready) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pim_result_collector.sv
// Scoreboard bench: unit handshakes push expected writes, memory handshakes pop them.
module tb_pim_result_collector;
    import pim_result_collector_pkg::*;

    localparam int NU = 4;
    localparam int MN = 4;
    localparam int G  = 2;
    localparam int T  = 2;
    localparam int TT = 4;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [9:0] base_addr;
    logic       busy, done;

    pim_result_collector_if #(.NUM_UNITS(NU), .DW(32), .AW(10)) bus ();

    pim_result_collector #(.NUM_UNITS(NU), .MAT_N(MN), .DW(32), .AW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    exp_t        sbq[$];
    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          gq[$];
    int          hit [1024];
    int          sent [NU];
    logic [31:0] dbase [NU];
    logic [NU-1:0] en = '0, hold = '0;
    logic [9:0]  mbase = '0;
    int          cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
    logic        pend_v = 1'b0, hold_v = 1'b0;
    logic [9:0]  pend_a, hold_a;
    logic [31:0] pend_d, hold_d;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] model_addr(input int u, input int kk);
        int tr, tc, r, c;
        tr = u / G;  tc = u % G;
        r  = kk / T; c  = kk % T;
        return 10'(int'(mbase) + (tr * T + r) * MN + tc * T + c);
    endfunction

    task automatic apply();
        for (int u = 0; u < NU; u++) begin
            bus.pim_valid[u] = en[u] && (sent[u] < TT || hold[u]);
            bus.pim_data[u]  = dbase[u] + 32'(sent[u]);
        end
    endtask

    task automatic mon();
        exp_t e;
        cyc++;
        if (pend_v) begin
            chk("lat_we",   int'(bus.mem_we),    1);
            chk("lat_addr", int'(bus.mem_addr),  int'(pend_a));
            chk("lat_data", int'(bus.mem_wdata), int'(pend_d));
        end
        if (hold_v) begin
            chk("hold_we",   int'(bus.mem_we),    1);
            chk("hold_addr", int'(bus.mem_addr),  int'(hold_a));
            chk("hold_data", int'(bus.mem_wdata), int'(hold_d));
        end
        pend_v = 1'b0;
        hold_v = 1'b0;
        if (rst) begin
            sbq.delete();
            for (int u = 0; u < NU; u++) sent[u] = 0;
            return;
        end
        chk("rdy_onehot", int'($onehot0(bus.pim_ready)), 1);
        if (bus.mem_we && bus.mem_ready) begin
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("wr_addr", int'(bus.mem_addr),  int'(e.addr));
                chk("wr_data", int'(bus.mem_wdata), int'(e.data));
            end
            wa.push_back(bus.mem_addr);
            wd.push_back(bus.mem_wdata);
            wc.push_back(cyc);
            hit[bus.mem_addr]++;
        end
        if (bus.mem_we && !bus.mem_ready) begin
            chk("stall_rdy", int'(bus.pim_ready), 0);
            hold_v = 1'b1;
            hold_a = bus.mem_addr;
            hold_d = bus.mem_wdata;
        end
        for (int u = 0; u < NU; u++) begin
            if (bus.pim_valid[u] && sent[u] >= TT)
                chk("done_unit_rdy", int'(bus.pim_ready[u]), 0);
            else if (bus.pim_valid[u] && bus.pim_ready[u]) begin
                e.addr = model_addr(u, sent[u]);
                e.data = dbase[u] + 32'(sent[u]);
                sbq.push_back(e);
                gq.push_back(u);
                pend_v = 1'b1;
                pend_a = e.addr;
                pend_d = e.data;
                sent[u]++;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start && !busy) begin
            mbase = base_addr;
            for (int u = 0; u < NU; u++) sent[u] = 0;
            start_cyc = cyc;
        end
    endtask

    task automatic cycle();
        apply();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); gq.delete();
        for (int i = 0; i < 1024; i++) hit[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; en = '0; hold = '0;
        bus.mem_ready = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic start_pass(input logic [9:0] b);
        base_addr = b;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int  d0;
        logic ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            cycle();
            if (done_cnt != d0) ok = 1'b1;
        end
        chk("done_seen", int'(ok), 1);
        chk("busy_clr", int'(busy), 0);
    endtask

    task automatic verify_full(input logic [9:0] b);
        chk("n_writes", wa.size(), 16);
        for (int a = 0; a < 16; a++)
            chk("addr_once", hit[(int'(b) + a) % 1024], 1);
    endtask

    initial begin
        int d0;
        logic [9:0] exp_a [4];
        exp_a[0] = 10'd10; exp_a[1] = 10'd11; exp_a[2] = 10'd14; exp_a[3] = 10'd15;
        for (int u = 0; u < NU; u++) begin
            sent[u]  = 0;
            dbase[u] = 32'h0;
        end
        base_addr = '0;

        // Reset state
        do_reset();
        chk("rst_we",    int'(bus.mem_we),    0);
        chk("rst_addr",  int'(bus.mem_addr),  0);
        chk("rst_wdata", int'(bus.mem_wdata), 0);
        chk("rst_ready", int'(bus.pim_ready), 0);
        chk("rst_busy",  int'(busy),          0);
        chk("rst_done",  int'(done),          0);

        // Single unit 3 only
        clear_log();
        dbase[3] = 32'hA0;
        en = 4'b1000;
        d0 = done_cnt;
        start_pass(10'd0);
        repeat (10) cycle();
        chk("u3_writes", wa.size(), 4);
        if (wa.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("u3_addr", int'(wa[i]), int'(exp_a[i]));
                chk("u3_data", int'(wd[i]), 32'hA0 + i);
            end
        chk("u3_no_done", done_cnt, d0);
        chk("u3_busy", int'(busy), 1);
        do_reset();

        // All units, full throughput
        clear_log();
        dbase[0] = 32'h100; dbase[1] = 32'h200; dbase[2] = 32'h300; dbase[3] = 32'h400;
        en = 4'hF;
        d0 = done_cnt;
        start_pass(10'd0);
        wait_done(40);
        verify_full(10'd0);
        for (int i = 0; i < gq.size(); i++) chk("rr_order", gq[i], i % 4);
        if (wc.size() == 16) begin
            chk("back_to_back", wc[15] - wc[0], 15);
            chk("done_after_last", done_cyc, wc[15] + 1);
        end
        chk("pass_len", done_cyc - start_cyc, MN * MN + 2);
        repeat (3) cycle();
        chk("done_pulses", done_cnt - d0, 1);

        // Backpressure mid-pass
        clear_log();
        start_pass(10'd0);
        repeat (5) cycle();
        bus.mem_ready = 1'b0;
        repeat (3) cycle();
        bus.mem_ready = 1'b1;
        wait_done(40);
        verify_full(10'd0);

        // Address wrap
        clear_log();
        start_pass(10'd1020);
        wait_done(40);
        verify_full(10'd1020);
        if (wa.size() == 16) begin
            chk("wrap_first_addr", int'(wa[0]),  1020);
            chk("wrap_first_data", int'(wd[0]),  int'(dbase[0]));
            chk("wrap_last_addr",  int'(wa[15]), 11);
            chk("wrap_last_data",  int'(wd[15]), int'(dbase[3]) + 3);
        end

        // Reset after 5 writes, then a clean pass
        clear_log();
        start_pass(10'd0);
        for (int i = 0; i < 30 && wa.size() < 5; i++) cycle();
        chk("pre_rst_writes", wa.size(), 5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_we",    int'(bus.mem_we),    0);
        chk("mid_rst_busy",  int'(busy),          0);
        chk("mid_rst_ready", int'(bus.pim_ready), 0);
        clear_log();
        start_pass(10'd0);
        wait_done(40);
        verify_full(10'd0);
        if (wd.size() > 0) chk("restart_k0", int'(wd[0]), int'(dbase[0]));

        // start while busy ignored; finished units keep valid high
        clear_log();
        hold = 4'hF;
        start_pass(10'd0);
        repeat (6) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(40);
        repeat (4) cycle();
        verify_full(10'd0);
        hold = '0;
        en = '0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
